// File: rtl/alu_defs.sv
// Shared ALU opcode, RV32I opcode and funct7 constants plus the decoded-op bundle.
package alu_defs;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]        alu_control;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [4:0]        rd_addr;
        logic              reg_write;
        logic              is_branch;
        logic              illegal;
    } alu_op_t;

    // Base-encoding (funct7=0) arithmetic op selected by funct3.
    function automatic logic [3:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode of instr/pc/register operands into an alu_op_t bundle.
// Latency 0; no handshake.
module alu_decode
    import alu_defs::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output alu_op_t           dec
);
    logic [6:0]        opcode, f7;
    logic [2:0]        f3;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] imm_i, imm_s, imm_u, shamt_x;
    logic              bad;
    logic              unused_rs1_idx;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign shamt   = instr[24:20];
    assign imm_i   = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u   = {{(DATA_W-32){instr[31]}}, instr[31:12], 12'b0};
    assign shamt_x = {{(DATA_W-5){1'b0}}, shamt};
    assign unused_rs1_idx = ^instr[19:15];

    always_comb begin
        dec             = '0;
        dec.alu_control = ALU_ADD;
        dec.op_a        = rs1_data;
        dec.op_b        = rs2_data;
        dec.rd_addr     = instr[11:7];
        dec.reg_write   = 1'b1;
        bad             = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (f7 == F7_ZERO)                 dec.alu_control = arith_op(f3);
                else if (f7 == F7_ALT && f3 == 3'b000) dec.alu_control = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101) dec.alu_control = ALU_SRA;
                else                               bad = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_control = arith_op(f3);
                dec.op_b        = imm_i;
                if (f3 == 3'b001) begin
                    dec.op_b = shamt_x;
                    bad      = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    dec.op_b = shamt_x;
                    if (f7 == F7_ALT)       dec.alu_control = ALU_SRA;
                    else if (f7 != F7_ZERO) bad = 1'b1;
                end
            end
            OPC_LOAD:  dec.op_b = imm_i;
            OPC_STORE: begin
                dec.op_b      = imm_s;
                dec.reg_write = 1'b0;
            end
            OPC_BRANCH: begin
                dec.reg_write = 1'b0;
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000:  dec.alu_control = ALU_BEQ;
                    3'b001:  dec.alu_control = ALU_BNE;
                    3'b100:  dec.alu_control = ALU_BLT;
                    3'b101:  dec.alu_control = ALU_BGE;
                    3'b110:  dec.alu_control = ALU_BLTU;
                    3'b111:  dec.alu_control = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.op_a = '0;
                dec.op_b = imm_u;
            end
            OPC_AUIPC: begin
                dec.op_a = pc;
                dec.op_b = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                dec.op_a = pc;
                dec.op_b = DATA_W'(4);
            end
            default: bad = 1'b1;
        endcase

        // Illegal ops travel as a harmless ADD 0,0 with no side effects.
        if (bad) begin
            dec.alu_control = ALU_ADD;
            dec.op_a        = '0;
            dec.op_b        = '0;
            dec.reg_write   = 1'b0;
            dec.is_branch   = 1'b0;
            dec.illegal     = 1'b1;
        end
        if (dec.rd_addr == 5'd0) dec.reg_write = 1'b0;
    end
endmodule

// File: rtl/fifo.sv
// Generic synchronous FIFO; latency 1 cycle push-to-pop; push_rdy derived from count only.
// Backpressure: push ignored when full, pop_dat held while pop_rdy is low. DEPTH must be a power of 2.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign push_rdy = (count < FULL);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/alu_issue.sv
// Decode + 2-entry skid buffer feeding the ALU; 1-cycle latency when empty, 1 op/cycle.
// in_ready depends only on buffer count (never on out_ready); ALU_ISSUE_STATS_EN adds issue/illegal counters.
module alu_issue
    import alu_defs::*;
#(
    parameter int XLEN  = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [4:0]      rd_addr,
    output logic            reg_write,
    output logic            is_branch,
    output logic            illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]     issue_count,
    output logic [15:0]     illegal_count
`endif
);
    alu_op_t                 dec, head;
    logic [$bits(alu_op_t)-1:0] pop_dat;
    logic                    push_rdy;

    alu_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec)
    );

    fifo #(
        .W     ($bits(alu_op_t)),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_rdy (push_rdy),
        .push_dat (dec),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (pop_dat)
    );

    assign in_ready = push_rdy && !rst;
    // Data outputs read as zero whenever nothing is being offered.
    assign head = out_valid ? alu_op_t'(pop_dat) : '0;

    assign alu_control = head.alu_control;
    assign op_a        = head.op_a;
    assign op_b        = head.op_b;
    assign rd_addr     = head.rd_addr;
    assign reg_write   = head.reg_write;
    assign is_branch   = head.is_branch;
    assign illegal     = head.illegal;

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count   <= '0;
            illegal_count <= '0;
        end else if (out_valid && out_ready) begin
            issue_count <= issue_count + 32'd1;
            if (head.illegal) illegal_count <= illegal_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue.sv
// Directed plus random bench for alu_issue against a queue-based reference model.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_control;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_addr;
    logic        reg_write, is_branch, illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] issue_count;
    logic [15:0] illegal_count;
    logic [31:0] m_issue = '0;
    logic [15:0] m_ill = '0;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t q[$];

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .rd_addr(rd_addr), .reg_write(reg_write),
        .is_branch(is_branch), .illegal(illegal)
`ifdef ALU_ISSUE_STATS_EN
        , .issue_count(issue_count), .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the ISA rules as table lookups.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        bit ok;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [3:0] arith [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
        logic [3:0] brt   [8] = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd12, 4'd13, 4'd14, 4'd15};
        logic [31:0] ii, is, iu;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        iu = {ins[31:12], 12'h000};
        e = '0; e.a = r1; e.b = r2; e.rd = ins[11:7]; e.rw = 1'b1; ok = 1'b1;
        case (op)
            7'h33: begin
                if (f7 == 7'h00) e.alu = arith[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
                else ok = 1'b0;
            end
            7'h13: begin
                e.b = ii; e.alu = arith[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = {27'd0, ins[24:20]};
                    if (f7 == 7'h20 && f3 == 3'd5) e.alu = 4'd7;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h03: e.b = ii;
            7'h23: begin e.b = is; e.rw = 1'b0; end
            7'h63: begin
                e.alu = brt[f3]; e.rw = 1'b0; e.br = 1'b1;
                ok = !(f3 == 3'd2 || f3 == 3'd3);
            end
            7'h37: begin e.a = 32'd0; e.b = iu; end
            7'h17: begin e.a = p; e.b = iu; end
            7'h6F, 7'h67: begin e.a = p; e.b = 32'd4; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin e = '0; e.rd = ins[11:7]; e.ill = 1'b1; end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7;
        logic [6:0] opc [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        int k, r;
        r = $urandom_range(0, 3);
        f7 = (r < 2) ? 7'h00 : (r == 2) ? 7'h20 : 7'($urandom);
        k = $urandom_range(0, 10);
        if (k > 8) return $urandom;
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc[k]};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input logic v);
        instr = i; rs1_data = a; rs2_data = b; in_valid = v; pc = $urandom;
    endtask

    // Compare against the model, then advance one clock and apply the handshakes to the model.
    task automatic step(output bit acc);
        bit deliver;
        chk("out_valid", {79'd0, out_valid}, {79'd0, q.size() > 0});
        chk("in_ready", {79'd0, in_ready}, {79'd0, q.size() < 2});
        if (q.size() > 0)
            chk("head", {4'd0, alu_control, op_a, op_b, rd_addr, reg_write, is_branch, illegal},
                {4'd0, q[0]});
`ifdef ALU_ISSUE_STATS_EN
        chk("issue_count", {48'd0, issue_count}, {48'd0, m_issue});
        chk("illegal_count", {64'd0, illegal_count}, {64'd0, m_ill});
`endif
        acc = in_valid && (q.size() < 2);
        deliver = out_ready && (q.size() > 0);
        if (deliver) begin
`ifdef ALU_ISSUE_STATS_EN
            m_issue++;
            if (q[0].ill) m_ill++;
`endif
            void'(q.pop_front());
        end
        if (acc) q.push_back(ref_decode(instr, pc, rs1_data, rs2_data));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int idx;
        logic [31:0] bp [3] = '{32'h002081B3, 32'h407302B3, 32'h40115093};

        #1;
        chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
        chk("rst_in_ready", {79'd0, in_ready}, 80'd0);
        chk("rst_op_a", {48'd0, op_a}, 80'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {79'd0, in_ready}, 80'd1);

        // ADD with explicit expectations one cycle later
        out_ready = 1'b1;
        drive(32'h002081B3, 32'd10, 32'd20, 1'b1);
        step(acc);
        drive(32'h0, 32'd0, 32'd0, 1'b0);
        chk("add_vld", {79'd0, out_valid}, 80'd1);
        chk("add_ctl", {76'd0, alu_control}, 80'd0);
        chk("add_a", {48'd0, op_a}, 80'd10);
        chk("add_b", {48'd0, op_b}, 80'd20);
        chk("add_rd", {75'd0, rd_addr}, 80'd3);
        chk("add_rw", {79'd0, reg_write}, 80'd1);
        step(acc);

        drive(32'h407302B3, 32'd7, 32'd3, 1'b1);
        step(acc);
        drive(32'h40115093, 32'hF000_0000, 32'd0, 1'b1);
        chk("sub_ctl", {76'd0, alu_control}, 80'd1);
        step(acc);
        drive(32'h0020C463, 32'hFFFF_FFFB, 32'd1, 1'b1);
        chk("srai_ctl", {76'd0, alu_control}, 80'd7);
        chk("srai_b", {48'd0, op_b}, 80'd1);
        chk("srai_rd", {75'd0, rd_addr}, 80'd1);
        step(acc);
        drive(32'h123450B7, 32'd5, 32'd6, 1'b1);
        chk("blt_ctl", {76'd0, alu_control}, 80'hC);
        chk("blt_br", {79'd0, is_branch}, 80'd1);
        chk("blt_rw", {79'd0, reg_write}, 80'd0);
        step(acc);
        drive(32'h00000000, 32'd1, 32'd2, 1'b1);
        chk("lui_a", {48'd0, op_a}, 80'd0);
        chk("lui_b", {48'd0, op_b}, 80'h12345000);
        step(acc);
        drive(32'h00002063, 32'd1, 32'd2, 1'b1);
        chk("ill0", {76'd0, illegal, reg_write, alu_control[1:0]}, 80'h8);
        step(acc);
        drive(32'h0, 32'd0, 32'd0, 1'b0);
        chk("ill_br", {74'd0, illegal, reg_write, alu_control}, 80'h20);
        step(acc);
`ifdef ALU_ISSUE_STATS_EN
        chk("illegal_count_2", {64'd0, illegal_count}, 80'd2);
`endif

        // Backpressure: three offers, two fit, then drain in order
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(bp[idx], 32'(c + 100), 32'(c + 200), 1'b1);
            step(acc);
            if (acc && idx < 2) idx++;
        end
        chk("bp_full_in_ready", {79'd0, in_ready}, 80'd0);
        chk("bp_idx", 80'(idx), 80'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 8 && (q.size() > 0 || in_valid); c++) begin
            step(acc);
            if (acc) drive(32'h0, 32'd0, 32'd0, 1'b0);
        end
        chk("bp_drained", 80'(q.size()), 80'd0);

        // Reset mid-operation with two entries buffered
        out_ready = 1'b0;
        drive(32'h002081B3, 32'd1, 32'd2, 1'b1);
        step(acc);
        step(acc);
        drive(32'h0, 32'd0, 32'd0, 1'b0);
        chk("pre_rst_full", {79'd0, in_ready}, 80'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {79'd0, out_valid}, 80'd0);
        chk("mid_rst_in_ready", {79'd0, in_ready}, 80'd0);
        chk("mid_rst_data", {4'd0, alu_control, op_a, op_b, rd_addr, reg_write, is_branch, illegal}, 80'd0);
        q.delete();
`ifdef ALU_ISSUE_STATS_EN
        m_issue = '0; m_ill = '0;
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", {79'd0, in_ready}, 80'd1);
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step(acc);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) drive(rand_instr(), $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 2) != 0);
            step(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step(acc);
        chk("final_empty", 80'(q.size()), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
